// File: rtl/xc_fifo_pkg.sv
// Shared types and constants for the FIFO burst-read consumer stage.
package xc_fifo_pkg;

  // Read-side sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Output buffer depth: two words in the buffer plus one read in flight
  // is the most the buffer can receive, so three entries absorb a full
  // stop of the downstream consumer without loss.
  localparam int unsigned BUF_DEPTH = 3;
  localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/xc_fifo_skid3.sv
// Three-entry data+last register queue. The head sits in entry 0; a pop shifts
// the remaining entries towards the head and a push lands just above them.
module xc_fifo_skid3
  import xc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_last_o,
  output logic             head_valid_o,
  output logic [CNT_W-1:0] count_o
);

  // The data width follows the module parameter, so the entry layout lives here.
  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           ent_q [BUF_DEPTH];
  entry_t           ent_d [BUF_DEPTH];
  entry_t           above [BUF_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             pop_eff;
  logic             push_eff;

  assign pop_eff  = pop_i && (count_q != '0);
  assign push_eff = push_i && ((count_q != CNT_W'(BUF_DEPTH)) || pop_eff);
  assign wr_idx   = count_q - CNT_W'(pop_eff);

  // The entry each slot inherits on a pop; the top slot refills with zeros so
  // the head reads back as 0 once the queue drains.
  genvar gi;
  for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_above
    if (gi == BUF_DEPTH - 1) begin : g_top
      assign above[gi] = '0;
    end else begin : g_mid
      assign above[gi] = ent_q[gi + 1];
    end
  end

  // Next queue contents: clear wins, then shift-on-pop, then write the push slot.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < BUF_DEPTH; i++) ent_d[i] = ent_q[i];
    if (clr_i) begin
      count_d = '0;
      for (int i = 0; i < BUF_DEPTH; i++) ent_d[i] = '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (pop_eff) ent_d[i] = above[i];
        if (push_eff && (wr_idx == CNT_W'(i))) begin
          ent_d[i].last = push_last_i;
          ent_d[i].data = push_data_i;
        end
      end
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  // Queue registers with asynchronous reset to empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign head_data_o  = ent_q[0].data;
  assign head_last_o  = ent_q[0].last;
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;

endmodule

// File: rtl/xc_fifo_burst_rd.sv
// Burst reader for the synchronous FIFO: drains full bursts when almost-empty
// drops, flushes stragglers after an idle timeout, and presents the words as a
// valid/ready stream with a last marker.
module xc_fifo_burst_rd
  import xc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned TMO_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [TMO_W-1:0] timeout_i,
  input  logic             fifo_ne_i,
  input  logic             fifo_ae_i,
  output logic             fifo_rd_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [LEN_W:0]   rem_q, rem_d;     // BURST: words still to issue; FLUSH: word cap
  logic [LEN_W:0]   cnt_q, cnt_d;     // words issued since entering BURST/FLUSH
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             inflight_q, inflight_d;
  logic             tag_q, tag_d;     // last tag of the burst read now in flight
  logic [LEN_W:0]   len_eff;
  logic [CNT_W-1:0] buf_count;
  logic             buf_valid;
  logic             rd_ok;
  logic             rd;
  logic             flush_last;
  logic             push_last;

  assign len_eff = (burst_len_i == '0) ? (LEN_W+1)'(1) : {1'b0, burst_len_i};

  // Never let buffered plus in-flight words exceed the buffer, so a stalled
  // consumer can never cause an overflow.
  assign rd_ok = ({1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W+1)'(BUF_DEPTH);

  // Next-state, counters and read strobe; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    tag_d      = tag_q;
    rd         = 1'b0;
    flush_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_ae_i) begin
          state_d = BURST;
          rem_d   = len_eff;
          cnt_d   = '0;
        end else if ((timeout_i != '0) && (tmo_q == timeout_i - TMO_W'(1)) && fifo_ne_i) begin
          state_d = FLUSH;
          rem_d   = len_eff;
          cnt_d   = '0;
        end else if (fifo_ne_i) begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
        end
      end
      BURST: begin
        if (fifo_ne_i && rd_ok) begin
          rd    = 1'b1;
          rem_d = rem_q - (LEN_W+1)'(1);
          cnt_d = cnt_q + (LEN_W+1)'(1);
          tag_d = (rem_q == (LEN_W+1)'(1));
          if (rem_q == (LEN_W+1)'(1)) state_d = IDLE;
        end
      end
      FLUSH: begin
        if (inflight_q) begin
          // The FIFO flags already reflect the captured read here.
          flush_last = !fifo_ne_i || (cnt_q == rem_q);
          if (flush_last) state_d = IDLE;
        end else if (fifo_ne_i && rd_ok) begin
          rd    = 1'b1;
          cnt_d = cnt_q + (LEN_W+1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) begin
      state_d = IDLE;
      rem_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      tag_d   = 1'b0;
    end
  end

  // The read issued this cycle returns data next cycle unless it is cleared.
  always_comb begin
    inflight_d = rd && !clr_i;
  end

  // Sequencer registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  assign push_last = (state_q == FLUSH) ? flush_last : tag_q;

  xc_fifo_skid3 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .push_i      (inflight_q && !clr_i),
    .push_data_i (fifo_data_i),
    .push_last_i (push_last),
    .pop_i       (buf_valid && m_ready_i),
    .head_data_o (m_data_o),
    .head_last_o (m_last_o),
    .head_valid_o(buf_valid),
    .count_o     (buf_count)
  );

  assign fifo_rd_o = rd;
  assign m_valid_o = buf_valid;
  assign busy_o    = (state_q != IDLE) || inflight_q || (buf_count != '0);

endmodule

// File: tb/tb_xc_fifo_burst_rd.sv
// Directed bench for xc_fifo_burst_rd with a small behavioural FIFO upstream.
module tb_xc_fifo_burst_rd;

  localparam int WIDTH = 32;
  localparam int LEN_W = 8;
  localparam int TMO_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             clr_i = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic [TMO_W-1:0] timeout = '0;
  logic             fifo_ne;
  logic             fifo_ae;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;

  always #5 clk_i = ~clk_i;

  xc_fifo_burst_rd #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .burst_len_i(burst_len),
    .timeout_i  (timeout),
    .fifo_ne_i  (fifo_ne),
    .fifo_ae_i  (fifo_ae),
    .fifo_rd_o  (fifo_rd),
    .fifo_data_i(fifo_data),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .busy_o     (busy)
  );

  // Behavioural FIFO: data one cycle after the read strobe, flags from occupancy.
  logic [WIDTH-1:0] fq[$];
  int               fcnt = 0;
  int               ae_count = 3;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_s = 1'b0;

  always @(negedge clk_i) rd_s = fifo_rd;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fq.delete();
      fifo_data <= '0;
      fcnt      <= 0;
    end else if (clr_i) begin
      fq.delete();
      fcnt <= 0;
    end else begin
      if (rd_s && fq.size() > 0) fifo_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fcnt <= fq.size();
    end
  end

  assign fifo_ne = (fcnt != 0);
  assign fifo_ae = (fcnt <= ae_count);

  // Output monitor: one line per accepted word.
  logic [WIDTH-1:0] out_d[$];
  logic             out_l[$];

  always @(negedge clk_i) begin
    if (!rst_i && m_valid && m_ready) begin
      out_d.push_back(m_data);
      out_l.push_back(m_last);
      $display("txn t=%0t data=%08h last=%0b", $time, m_data, m_last);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic write_words(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + WIDTH'(i);
      step(1);
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_rd(input string tag, input int budget, output int waited);
    waited = 0;
    while (!fifo_rd && waited < budget) begin
      step(1);
      waited++;
    end
    chk({tag, "_rd_start"}, 64'(fifo_rd), 64'd1);
  endtask

  task automatic wait_last(input string tag, input int budget);
    int w;
    bit seen;
    w = 0;
    seen = 1'b0;
    while (!seen && w < budget) begin
      step(1);
      w++;
      seen = (out_l.size() > 0) && out_l[out_l.size()-1];
    end
    chk({tag, "_last_seen"}, 64'(seen), 64'd1);
  endtask

  logic [15:0]      rd_v, v_v, l_v, b_v;
  logic [WIDTH-1:0] d_a[16];

  task automatic record(input int n);
    rd_v = '0; v_v = '0; l_v = '0; b_v = '0;
    for (int k = 0; k < n; k++) begin
      rd_v[k] = fifo_rd;
      v_v[k]  = m_valid;
      l_v[k]  = m_last;
      b_v[k]  = busy;
      d_a[k]  = m_data;
      step(1);
    end
  endtask

  task automatic check_words(input string tag, input int n, input logic [WIDTH-1:0] base);
    logic [15:0] lv;
    chk({tag, "_count"}, 64'(out_d.size()), 64'(n));
    lv = '0;
    for (int i = 0; i < n && i < out_d.size(); i++) begin
      chk({tag, "_data"}, 64'(out_d[i]), 64'(base + WIDTH'(i)));
      lv[i] = out_l[i];
    end
    chk({tag, "_last_pos"}, 64'(lv), 64'(16'd1 << (n - 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rdn;
    bit dstable;

    // Reset state.
    step(2);
    chk("rst_rd", 64'(fifo_rd), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_i = 1'b0;
    step(1);

    // 1: full burst of 4 with ready high.
    burst_len = 8'd4; ae_count = 3; timeout = '0; m_ready = 1'b1;
    write_words(4, 32'h1000_0000);
    wait_rd("t1", 10, w);
    record(8);
    chk("t1_rd_pattern", 64'(rd_v[7:0]), 64'h0F);
    chk("t1_valid_pattern", 64'(v_v[7:0]), 64'h3C);
    chk("t1_last_pattern", 64'(l_v[7:0]), 64'h20);
    chk("t1_busy_pattern", 64'(b_v[7:0]), 64'h3F);
    for (int k = 2; k < 6; k++) chk("t1_data", 64'(d_a[k]), 64'(32'h1000_0000 + 32'(k - 2)));

    // 2: burst of 8 against a stalled consumer.
    out_d.delete(); out_l.delete();
    burst_len = 8'd8; ae_count = 7; m_ready = 1'b0;
    write_words(8, 32'h2000_0000);
    wait_rd("t2", 10, w);
    rdn = 0; dstable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (fifo_rd) rdn++;
      if (k >= 2 && m_data !== 32'h2000_0000) dstable = 1'b0;
      step(1);
    end
    chk("t2_reads_held", 64'(rdn), 64'd3);
    chk("t2_valid_held", 64'(m_valid), 64'd1);
    chk("t2_head_held", 64'(m_data), 64'h2000_0000);
    chk("t2_head_stable", 64'(dstable), 64'd1);
    m_ready = 1'b1;
    wait_last("t2", 40);
    check_words("t2", 8, 32'h2000_0000);
    step(1);
    chk("t2_idle", 64'(busy), 64'd0);

    // 3: two stranded words flushed after the timeout.
    out_d.delete(); out_l.delete();
    burst_len = 8'd8; ae_count = 7; timeout = 8'd10;
    write_words(2, 32'h3000_0000);
    wait_rd("t3", 30, w);
    chk("t3_flush_delay", 64'(w), 64'd9);
    record(8);
    chk("t3_rd_pattern", 64'(rd_v[7:0]), 64'h05);
    chk("t3_valid_pattern", 64'(v_v[7:0]), 64'h14);
    chk("t3_last_pattern", 64'(l_v[7:0]), 64'h10);
    chk("t3_busy_pattern", 64'(b_v[7:0]), 64'h1F);
    chk("t3_data0", 64'(d_a[2]), 64'h3000_0000);
    chk("t3_data1", 64'(d_a[4]), 64'h3000_0001);
    timeout = '0;

    // 4: burst starved mid-way, then resumed.
    out_d.delete(); out_l.delete();
    burst_len = 8'd4; ae_count = 1;
    write_words(2, 32'h4000_0000);
    wait_rd("t4", 10, w);
    step(8);
    chk("t4_stall_words", 64'(out_d.size()), 64'd2);
    chk("t4_stall_valid", 64'(m_valid), 64'd0);
    chk("t4_stall_busy", 64'(busy), 64'd1);
    write_words(2, 32'h4000_0002);
    wait_last("t4", 20);
    check_words("t4", 4, 32'h4000_0000);
    step(1);
    chk("t4_idle", 64'(busy), 64'd0);

    // 5: clear with a read in flight and two words buffered.
    out_d.delete(); out_l.delete();
    burst_len = 8'd8; ae_count = 7; m_ready = 1'b0;
    write_words(8, 32'h5000_0000);
    wait_rd("t5", 10, w);
    step(3);
    chk("t5_pre_valid", 64'(m_valid), 64'd1);
    chk("t5_pre_rd_gated", 64'(fifo_rd), 64'd0);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    chk("t5_clr_valid", 64'(m_valid), 64'd0);
    chk("t5_clr_busy", 64'(busy), 64'd0);
    chk("t5_clr_data", 64'(m_data), 64'd0);
    m_ready = 1'b1;
    step(10);
    chk("t5_no_stray", 64'(out_d.size()), 64'd0);

    // 6: asynchronous reset mid-burst, then a fresh burst.
    burst_len = 8'd4; ae_count = 3; m_ready = 1'b0;
    write_words(4, 32'h6000_0000);
    wait_rd("t6", 10, w);
    step(2);
    chk("t6_pre_valid", 64'(m_valid), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_rst_rd", 64'(fifo_rd), 64'd0);
    chk("t6_rst_valid", 64'(m_valid), 64'd0);
    chk("t6_rst_data", 64'(m_data), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    step(2);
    rst_i = 1'b0;
    out_d.delete(); out_l.delete();
    m_ready = 1'b1;
    step(1);
    write_words(4, 32'h6100_0000);
    wait_rd("t6b", 10, w);
    wait_last("t6b", 20);
    check_words("t6b", 4, 32'h6100_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
